instr_exec_unit: RTL
====================

Name: instr_exec_unit

Overview:
- Execution stage directly downstream of instr_register: consumes one instruction word {opc, op_a, op_b} per handshake and produces a signed result.
- Single-cycle path for ZERO, PASSA, PASSB, ADD, SUB and MULT; iterative multi-cycle path for DIV and MOD.
- Valid/ready on both sides, so the read-side sequencer and the result consumer can stall independently.

Parameters:
- OP_WIDTH, 32, operand width in bits; operands are signed.
- RES_WIDTH, 64, result width in bits; must equal 2*OP_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction presented.
- in_ready  output  1  unit can accept an instruction this cycle.
- in_opc  input  4  opcode_t: 0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD.
- in_op_a  input  OP_WIDTH  signed operand a.
- in_op_b  input  OP_WIDTH  signed operand b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_result  output  RES_WIDTH  signed result.
- out_opc  output  4  opcode of the instruction that produced out_result.
- out_err  output  1  divide by zero, or illegal opcode (8-15).
- busy  output  1  high in DIVIDE state.

Behaviour:
- Reset (asynchronous, any state including mid-divide):
  - state=IDLE; in-flight divide discarded.
  - out_valid=0, out_result=0, out_opc=0, out_err=0, busy=0.
- Acceptance:
  - in_ready = (state==IDLE) && (!out_valid || out_ready); combinational.
  - Accept occurs when in_valid && in_ready at a clock edge.
- States and transitions:
  - IDLE: on accept of a single-cycle op -> stay IDLE, load outputs. On accept of DIV/MOD with op_b!=0 -> DIVIDE.
  - DIVIDE: counter runs OP_WIDTH cycles -> IDLE, loading outputs.
- Single-cycle ops:
  - Result registered at the accept edge; out_valid=1 the next cycle (latency 1).
  - Throughput 1/cycle while out_ready=1.
- Arithmetic (result always RES_WIDTH, signed):
  - ZERO -> 0.
  - PASSA/PASSB -> sign-extended operand.
  - ADD/SUB -> operands sign-extended first, so no overflow.
  - MULT -> full signed product.
- DIV/MOD:
  - Restoring divider on magnitudes, one quotient bit per cycle, OP_WIDTH cycles.
  - Signs corrected afterwards: quotient truncates toward zero; remainder takes the dividend's sign.
  - out_valid asserts OP_WIDTH+1 cycles after the accept edge.
  - -2^(OP_WIDTH-1) / -1 yields +2^(OP_WIDTH-1) (fits in RES_WIDTH).
- Divide by zero: no DIVIDE state; latency 1, out_result=0, out_err=1.
- Illegal opcode (8-15): latency 1, out_result=0, out_err=1.
- Output hold:
  - While out_valid && !out_ready, out_result/out_opc/out_err stay stable and in_ready=0.
  - out_valid clears after the out_ready handshake unless a new result loads on the same edge.
- Simultaneous events: output handshake and new accept on the same edge -> the new result replaces the old one, with no bubble.
- Changes on in_* while in_ready=0 are ignored.

Optional Feature:
- Macro EXEC_INSTR_COUNT_EN.
- Defined:
  - Adds output port instr_count, 32 bits, unsigned.
  - Increments by 1 on every output handshake (out_valid && out_ready), including error results.
  - Wraps 0xFFFFFFFF -> 0; reset to 0 by reset_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then ADD a=-15 b=7, out_ready=1 -> out_valid exactly 1 cycle later, out_result=-8, out_err=0, out_opc=3.
- Back-to-back PASSA 5, SUB 3-10, MULT -15*15 with out_ready=1 -> results 5, -7, -225 on three consecutive cycles, in_ready never low.
- DIV -15/4 then MOD -15/4:
  - out_valid exactly 33 cycles after each accept; results -3 and -3.
  - busy=1 and in_ready=0 during DIVIDE.
- DIV 9/0 -> latency 1, out_result=0, out_err=1. Then opcode 12 -> out_result=0, out_err=1.
- Backpressure: out_ready=0 for 5 cycles after ADD 1+2 -> out_result held at 3, in_ready=0. Pending MULT accepted on the out_ready=1 edge; product appears next cycle.
- Assert reset_n=0 at divide cycle 10 of DIV 100/7 -> outputs zero immediately. After release, ADD 1+1 returns 2 with no stale quotient. With EXEC_INSTR_COUNT_EN, instr_count=0 after reset.

Source files
------------

// File: rtl/instr_exec_unit.sv
// Execution stage: single-cycle ALU ops plus an iterative restoring divider for DIV/MOD.
// Optional instr_count output port and counter enabled by defining EXEC_INSTR_COUNT_EN.
module instr_exec_unit #(
  parameter int unsigned OP_WIDTH  = 32,
  parameter int unsigned RES_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opc,
  input  logic [OP_WIDTH-1:0]  in_op_a,
  input  logic [OP_WIDTH-1:0]  in_op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RES_WIDTH-1:0] out_result,
  output logic [3:0]           out_opc,
  output logic                 out_err,
  output logic                 busy
`ifdef EXEC_INSTR_COUNT_EN
  ,
  output logic [31:0]          instr_count
`endif
);

  localparam int unsigned CNT_W = $clog2(OP_WIDTH);
  localparam int unsigned EXT_W = RES_WIDTH - OP_WIDTH;

  localparam logic [3:0] OPC_ZERO  = 4'd0;
  localparam logic [3:0] OPC_PASSA = 4'd1;
  localparam logic [3:0] OPC_PASSB = 4'd2;
  localparam logic [3:0] OPC_ADD   = 4'd3;
  localparam logic [3:0] OPC_SUB   = 4'd4;
  localparam logic [3:0] OPC_MULT  = 4'd5;
  localparam logic [3:0] OPC_DIV   = 4'd6;
  localparam logic [3:0] OPC_MOD   = 4'd7;

  typedef enum logic {IDLE, DIVIDE} state_t;

  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [RES_WIDTH-1:0]  out_result_q, out_result_d;
  logic [3:0]            out_opc_q, out_opc_d;
  logic                  out_err_q, out_err_d;
  logic [OP_WIDTH-1:0]   rem_q, rem_d;
  logic [OP_WIDTH-1:0]   quo_q, quo_d;
  logic [OP_WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic [3:0]            div_opc_q, div_opc_d;

  logic                  accept;
  logic [RES_WIDTH-1:0]  ext_a, ext_b, alu_res, q_ext, r_ext;
  logic                  alu_err, alu_div;
  logic [OP_WIDTH-1:0]   a_mag, b_mag, rem_next, quo_next;
  logic [OP_WIDTH:0]     rem_shift, rem_sub;
  logic                  q_bit;

  assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_opc    = out_opc_q;
  assign out_err    = out_err_q;
  assign busy       = (state_q == DIVIDE);

  assign ext_a = {{EXT_W{in_op_a[OP_WIDTH-1]}}, in_op_a};
  assign ext_b = {{EXT_W{in_op_b[OP_WIDTH-1]}}, in_op_b};
  assign a_mag = in_op_a[OP_WIDTH-1] ? (~in_op_a + OP_WIDTH'(1)) : in_op_a;
  assign b_mag = in_op_b[OP_WIDTH-1] ? (~in_op_b + OP_WIDTH'(1)) : in_op_b;

  // One restoring step: shift next dividend bit into the partial remainder, trial-subtract.
  assign rem_shift = {rem_q, quo_q[OP_WIDTH-1]};
  assign rem_sub   = rem_shift - {1'b0, dvs_q};
  assign q_bit     = !rem_sub[OP_WIDTH];
  assign rem_next  = q_bit ? rem_sub[OP_WIDTH-1:0] : rem_shift[OP_WIDTH-1:0];
  assign quo_next  = {quo_q[OP_WIDTH-2:0], q_bit};
  assign q_ext     = {{EXT_W{1'b0}}, quo_next};
  assign r_ext     = {{EXT_W{1'b0}}, rem_next};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    alu_div = 1'b0;
    case (in_opc)
      OPC_ZERO:  alu_res = '0;
      OPC_PASSA: alu_res = ext_a;
      OPC_PASSB: alu_res = ext_b;
      OPC_ADD:   alu_res = ext_a + ext_b;
      OPC_SUB:   alu_res = ext_a - ext_b;
      OPC_MULT:  alu_res = ext_a * ext_b;
      OPC_DIV, OPC_MOD: begin
        if (in_op_b == '0) alu_err = 1'b1;
        else               alu_div = 1'b1;
      end
      default:   alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_result_d = out_result_q;
    out_opc_d    = out_opc_q;
    out_err_d    = out_err_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvs_d        = dvs_q;
    cnt_d        = cnt_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    div_opc_d    = div_opc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (alu_div) begin
            state_d   = DIVIDE;
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            cnt_d     = '0;
            q_neg_d   = in_op_a[OP_WIDTH-1] ^ in_op_b[OP_WIDTH-1];
            r_neg_d   = in_op_a[OP_WIDTH-1];
            div_opc_d = in_opc;
          end else begin
            out_valid_d  = 1'b1;
            out_result_d = alu_res;
            out_opc_d    = in_opc;
            out_err_d    = alu_err;
          end
        end
      end
      DIVIDE: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        // Last step: apply signs (quotient toward zero, remainder follows dividend).
        if (cnt_q == CNT_W'(OP_WIDTH - 1)) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          out_opc_d   = div_opc_q;
          out_err_d   = 1'b0;
          if (div_opc_q == OPC_MOD)
            out_result_d = r_neg_q ? (~r_ext + RES_WIDTH'(1)) : r_ext;
          else
            out_result_d = q_neg_q ? (~q_ext + RES_WIDTH'(1)) : q_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_opc_q    <= '0;
      out_err_q    <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      cnt_q        <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      div_opc_q    <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_opc_q    <= out_opc_d;
      out_err_q    <= out_err_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvs_q        <= dvs_d;
      cnt_q        <= cnt_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
      div_opc_q    <= div_opc_d;
    end
  end

`ifdef EXEC_INSTR_COUNT_EN
  logic [31:0] instr_count_q, instr_count_d;

  // Counts every output handshake, error results included; wraps naturally.
  always_comb begin
    instr_count_d = instr_count_q;
    if (out_valid_q && out_ready) instr_count_d = instr_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) instr_count_q <= '0;
    else          instr_count_q <= instr_count_d;
  end

  assign instr_count = instr_count_q;
`endif

endmodule
